// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: command bytes, geometry and the writer FSM states.
package fb_pkg;

    // Framebuffer geometry: 40 x 30 cells of 16x16 pixels each.
    localparam int FB_DEPTH      = 1200;
    localparam int FB_ADDR_WIDTH = 11;

    // Command bytes sent by the Arduino as the first byte of a frame.
    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_STREAM   = 8'h02;
    localparam logic [7:0] CMD_FILL     = 8'h03;

    // Command parser states of the SPI writer.
    typedef enum logic [2:0] {
        ST_CMD      = 3'd0,
        ST_ADDR_HI  = 3'd1,
        ST_ADDR_LO  = 3'd2,
        ST_STREAM   = 3'd3,
        ST_FILL_VAL = 3'd4,
        ST_FILL     = 3'd5,
        ST_DISCARD  = 3'd6
    } fbState_e;

endpackage

// File: rtl/spi_slave_rx.sv
// Oversampled SPI mode-0 receiver: synchronizes the pins, detects SCLK rising
// edges and assembles MSB-first bytes while chip select is asserted.
module spi_slave_rx
    import fb_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       csN_i,
    output logic [7:0] dataByte_o,
    output logic       byteValid_o,
    output logic       csActive_o
);

    logic       sclkMeta_q, sclkSync_q, sclkPrev_q;
    logic       mosiMeta_q, mosiSync_q;
    logic       csMeta_q, csSync_q;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] dataByte_q, dataByte_d;
    logic       byteValid_q, byteValid_d;
    logic       sclkRise;

    assign sclkRise = sclkSync_q & ~sclkPrev_q;

    // Two-flop synchronizers for all pins plus the SCLK history flop for edge detect.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclkMeta_q <= 1'b0;
            sclkSync_q <= 1'b0;
            sclkPrev_q <= 1'b0;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
            csMeta_q   <= 1'b1;
            csSync_q   <= 1'b1;
        end else begin
            sclkMeta_q <= sclk_i;
            sclkSync_q <= sclkMeta_q;
            sclkPrev_q <= sclkSync_q;
            mosiMeta_q <= mosi_i;
            mosiSync_q <= mosiMeta_q;
            csMeta_q   <= csN_i;
            csSync_q   <= csMeta_q;
        end
    end

    // Shift in one bit per SCLK rise; an inactive chip select drops any partial byte.
    always_comb begin
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        dataByte_d  = dataByte_q;
        byteValid_d = 1'b0;
        if (csSync_q) begin
            bitCnt_d = 3'd0;
            shift_d  = 7'd0;
        end else if (sclkRise) begin
            shift_d  = {shift_q[5:0], mosiSync_q};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
                dataByte_d  = {shift_q, mosiSync_q};
                byteValid_d = 1'b1;
            end
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bitCnt_q    <= 3'd0;
            shift_q     <= 7'd0;
            dataByte_q  <= 8'd0;
            byteValid_q <= 1'b0;
        end else begin
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            dataByte_q  <= dataByte_d;
            byteValid_q <= byteValid_d;
        end
    end

    assign dataByte_o  = dataByte_q;
    assign byteValid_o = byteValid_q;
    assign csActive_o  = ~csSync_q;

endmodule

// File: rtl/fb_spi_writer.sv
// SPI command parser that owns the framebuffer RAM write port: address set,
// streamed pixel writes with wrap-around, and a full-buffer fill sweep.
module fb_spi_writer
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DEPTH      = FB_DEPTH
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  SPI_SCLK,
    input  logic                  SPI_MOSI,
    input  logic                  SPI_CS_n,
    output logic [ADDR_WIDTH-1:0] w_address,
    output logic [7:0]            w_data,
    output logic                  w_en,
    output logic                  fill_busy,
    output logic                  cmd_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [7:0] rxByte;
    logic       rxValid;
    logic       csActive;

    fbState_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] fillCnt_q, fillCnt_d;
    logic [ADDR_WIDTH-9:0] addrHi_q, addrHi_d;
    logic [ADDR_WIDTH-1:0] wAddr_q, wAddr_d;
    logic [7:0]            wData_q, wData_d;
    logic                  wEn_q, wEn_d;
    logic                  fillBusy_q, fillBusy_d;
    logic                  cmdError_q, cmdError_d;
    logic [ADDR_WIDTH-1:0] addrCand;

    spi_slave_rx uRx (
        .clk_i       (CLOCK_50),
        .reset_i     (reset),
        .sclk_i      (SPI_SCLK),
        .mosi_i      (SPI_MOSI),
        .csN_i       (SPI_CS_n),
        .dataByte_o  (rxByte),
        .byteValid_o (rxValid),
        .csActive_o  (csActive)
    );

    // Address bits above the buffer width are dropped (mod 2^ADDR_WIDTH).
    assign addrCand = {addrHi_q, rxByte};

    // Command FSM: parse bytes, produce write strobes and advance the pointer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fillCnt_d  = fillCnt_q;
        addrHi_d   = addrHi_q;
        wAddr_d    = wAddr_q;
        wData_d    = wData_q;
        wEn_d      = 1'b0;
        fillBusy_d = 1'b0;
        cmdError_d = 1'b0;

        case (state_q)
            ST_CMD: begin
                if (rxValid) begin
                    case (rxByte)
                        CMD_SET_ADDR: state_d = ST_ADDR_HI;
                        CMD_STREAM:   state_d = ST_STREAM;
                        CMD_FILL:     state_d = ST_FILL_VAL;
                        default: begin
                            cmdError_d = 1'b1;
                            state_d    = ST_DISCARD;
                        end
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (rxValid) begin
                    addrHi_d = rxByte[ADDR_WIDTH-9:0];
                    state_d  = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (rxValid) begin
                    ptr_d   = (addrCand > LAST_ADDR) ? '0 : addrCand;
                    state_d = ST_DISCARD;
                end
            end
            ST_STREAM: begin
                if (rxValid) begin
                    wEn_d   = 1'b1;
                    wAddr_d = ptr_q;
                    wData_d = rxByte;
                    ptr_d   = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
                end
            end
            ST_FILL_VAL: begin
                if (rxValid) begin
                    wEn_d      = 1'b1;
                    fillBusy_d = 1'b1;
                    wAddr_d    = '0;
                    wData_d    = rxByte;
                    fillCnt_d  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                wEn_d      = 1'b1;
                fillBusy_d = 1'b1;
                wAddr_d    = fillCnt_q;
                fillCnt_d  = fillCnt_q + 1'b1;
                if (fillCnt_q == LAST_ADDR) begin
                    ptr_d   = '0;
                    // A frame still open when the sweep ends must not have its
                    // remaining bytes parsed as a command.
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                state_d = ST_DISCARD;
            end
            default: begin
                state_d = ST_CMD;
            end
        endcase

        // A deselected SPI bus ends the frame; only a running fill survives it.
        if (!csActive && state_d != ST_FILL) begin
            state_d = ST_CMD;
        end
    end

    // FSM, pointer and registered RAM write port.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_CMD;
            ptr_q      <= '0;
            fillCnt_q  <= '0;
            addrHi_q   <= '0;
            wAddr_q    <= '0;
            wData_q    <= 8'd0;
            wEn_q      <= 1'b0;
            fillBusy_q <= 1'b0;
            cmdError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            fillCnt_q  <= fillCnt_d;
            addrHi_q   <= addrHi_d;
            wAddr_q    <= wAddr_d;
            wData_q    <= wData_d;
            wEn_q      <= wEn_d;
            fillBusy_q <= fillBusy_d;
            cmdError_q <= cmdError_d;
        end
    end

    assign w_address = wAddr_q;
    assign w_data    = wData_q;
    assign w_en      = wEn_q;
    assign fill_busy = fillBusy_q;
    assign cmd_error = cmdError_q;

endmodule

// File: tb/tb_fb_spi_writer.sv
// Bench for fb_spi_writer: drives SPI frames and compares every RAM write
// against a simple pointer/queue model of the command protocol.
module tb_fb_spi_writer;

    localparam int DEPTH = 1200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spiSclk = 1'b0;
    logic        spiMosi = 1'b0;
    logic        spiCsN = 1'b1;
    logic [10:0] wAddress;
    logic [7:0]  wData;
    logic        wEn;
    logic        fillBusy;
    logic        cmdError;

    int testCount = 0;
    int failCount = 0;

    logic [18:0] obsQ[$];
    logic [18:0] expQ[$];
    logic [7:0]  txQ[$];
    int          errCount = 0;
    int          expErr = 0;
    int          busyCount = 0;
    int          mPtr = 0;

    fb_spi_writer dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .SPI_SCLK  (spiSclk),
        .SPI_MOSI  (spiMosi),
        .SPI_CS_n  (spiCsN),
        .w_address (wAddress),
        .w_data    (wData),
        .w_en      (wEn),
        .fill_busy (fillBusy),
        .cmd_error (cmdError)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Record every write strobe, error pulse and busy cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wEn === 1'b1) obsQ.push_back({wAddress, wData});
            if (cmdError === 1'b1) errCount++;
            if (fillBusy === 1'b1) busyCount++;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: SET_ADDR loads the pointer with range fold-back to zero.
    task automatic mSetAddr(input int value);
        mPtr = value % 2048;
        if (mPtr >= DEPTH) mPtr = 0;
    endtask

    // Reference model: a streamed byte lands at the pointer, which then wraps at DEPTH.
    task automatic mStream(input logic [7:0] b);
        expQ.push_back({11'(mPtr), b});
        mPtr = (mPtr + 1) % DEPTH;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spiMosi = b[7-i];
            repeat (4) @(negedge clk);
            spiSclk = 1'b1;
            repeat (4) @(negedge clk);
            spiSclk = 1'b0;
        end
    endtask

    // Send one CS-low frame holding txQ, optionally followed by a truncated byte.
    task automatic applyStimulus(input int extraBits, input logic [7:0] extraVal);
        spiCsN = 1'b0;
        repeat (4) @(negedge clk);
        foreach (txQ[i]) sendBits(txQ[i], 8);
        if (extraBits > 0) sendBits(extraVal, extraBits);
        repeat (8) @(negedge clk);
        spiCsN = 1'b1;
        repeat (12) @(negedge clk);
        txQ.delete();
    endtask

    // Compare the recorded writes and error pulses against the model, then clear.
    task automatic checkOutput(input string tag);
        int bad;
        int n;
        checkVal({tag, "_count"}, obsQ.size(), expQ.size());
        bad = 0;
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            if (obsQ[i] !== expQ[i]) begin
                if (bad == 0)
                    $display("[TB] %s write #%0d: got addr %0d data %h, want addr %0d data %h",
                             tag, i, obsQ[i][18:8], obsQ[i][7:0], expQ[i][18:8], expQ[i][7:0]);
                bad++;
            end
        end
        checkVal({tag, "_entries_bad"}, bad, 0);
        checkVal({tag, "_cmd_error"}, errCount, expErr);
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic waitFillDone(input string tag);
        int n;
        n = 0;
        while (fillBusy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, "_done_in_time"}, 32'(n < 4000), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int choice;
        int value;
        int count;
        int n;
        logic [7:0] b;

        // Reset state.
        repeat (5) @(negedge clk);
        checkVal("reset_w_en", wEn, 0);
        checkVal("reset_w_address", wAddress, 0);
        checkVal("reset_w_data", wData, 0);
        checkVal("reset_fill_busy", fillBusy, 0);
        checkVal("reset_cmd_error", cmdError, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // SET_ADDR 10 then STREAM E0 1C 03, then one more byte to show ptr = 13.
        txQ = '{8'h01, 8'h00, 8'h0A}; applyStimulus(0, 8'h00); mSetAddr(10);
        txQ = '{8'h02, 8'hE0, 8'h1C, 8'h03}; applyStimulus(0, 8'h00);
        mStream(8'hE0); mStream(8'h1C); mStream(8'h03);
        txQ = '{8'h02, 8'h44}; applyStimulus(0, 8'h00); mStream(8'h44);
        checkOutput("set_stream");

        // Wrap at the end of the buffer.
        txQ = '{8'h01, 8'h04, 8'hAF}; applyStimulus(0, 8'h00); mSetAddr(16'h04AF);
        txQ = '{8'h02, 8'hAA, 8'hBB}; applyStimulus(0, 8'h00);
        mStream(8'hAA); mStream(8'hBB);
        checkOutput("wrap");

        // Out-of-range address folds to 0.
        txQ = '{8'h01, 8'h07, 8'hD0}; applyStimulus(0, 8'h00); mSetAddr(16'h07D0);
        txQ = '{8'h02, 8'h55}; applyStimulus(0, 8'h00); mStream(8'h55);
        checkOutput("out_of_range");

        // Unknown command: one error pulse, remaining bytes ignored.
        txQ = '{8'h7F, 8'h12}; applyStimulus(0, 8'h00); expErr++;
        checkOutput("bad_cmd");

        // Truncated SET_ADDR leaves the pointer alone.
        txQ = '{8'h01, 8'h05}; applyStimulus(0, 8'h00);
        txQ = '{8'h02, 8'h66}; applyStimulus(0, 8'h00); mStream(8'h66);
        checkOutput("truncated_addr");

        // CS raised after 5 bits: no write, next frame parsed from its command.
        txQ = '{8'h02}; applyStimulus(5, 8'hA5);
        txQ = '{8'h02, 8'h77}; applyStimulus(0, 8'h00); mStream(8'h77);
        checkOutput("cs_abort");

        // FILL with an attempted STREAM frame during the sweep.
        busyCount = 0;
        txQ = '{8'h03, 8'hFF}; applyStimulus(0, 8'h00);
        txQ = '{8'h02, 8'h11, 8'h22}; applyStimulus(0, 8'h00);
        waitFillDone("fill");
        checkVal("fill_busy_cycles", busyCount, DEPTH);
        for (int a = 0; a < DEPTH; a++) expQ.push_back({11'(a), 8'hFF});
        mPtr = 0;
        checkOutput("fill");
        txQ = '{8'h02, 8'h3C}; applyStimulus(0, 8'h00); mStream(8'h3C);
        checkOutput("after_fill");

        // Randomized frames against the model.
        for (int k = 0; k < 12; k++) begin
            choice = $urandom_range(0, 2);
            if (choice == 0) begin
                value = $urandom_range(0, 65535);
                txQ = '{8'h01, 8'(value >> 8), 8'(value)};
                applyStimulus(0, 8'h00);
                mSetAddr(value);
            end else if (choice == 1) begin
                count = $urandom_range(1, 4);
                txQ.push_back(8'h02);
                for (int j = 0; j < count; j++) begin
                    b = 8'($urandom_range(0, 255));
                    txQ.push_back(b);
                    mStream(b);
                end
                applyStimulus(0, 8'h00);
            end else begin
                txQ = '{8'($urandom_range(4, 255)), 8'($urandom_range(0, 255))};
                applyStimulus(0, 8'h00);
                expErr++;
            end
            checkOutput($sformatf("random_%0d", k));
        end

        // Reset asserted mid-FILL from a nonzero pointer.
        txQ = '{8'h01, 8'h01, 8'hF4}; applyStimulus(0, 8'h00); mSetAddr(500);
        txQ = '{8'h03, 8'hC3}; applyStimulus(0, 8'h00);
        n = 0;
        while (fillBusy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal("reset_fill_started", fillBusy, 1);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkVal("reset_mid_fill_w_en", wEn, 0);
        checkVal("reset_mid_fill_busy", fillBusy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        obsQ.delete();
        expQ.delete();
        mPtr = 0;
        txQ = '{8'h02, 8'h81}; applyStimulus(0, 8'h00); mStream(8'h81);
        checkOutput("after_reset");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
